// File: rtl/data_mem_responder_if.sv
// Memory-stage bundle between the pipeline (master) and the data-memory responder (slave).
interface data_mem_responder_if;
   logic [15:0] addr;
   logic [15:0] writeData;
   logic        memRead;
   logic        memWrite;
   logic [15:0] readData;
   logic        done;
   logic        stall;
   logic        err;

   modport master (
      output addr, writeData, memRead, memWrite,
      input  readData, done, stall, err
   );

   modport slave (
      input  addr, writeData, memRead, memWrite,
      output readData, done, stall, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: answers pipeline loads/stores after LATENCY cycles, stalling meanwhile.
// state  | meaning
// IDLE   | no access outstanding
// BUSY   | access in flight, cnt_q counts down to completion
// DONE   | completion cycle; a new request may be accepted back-to-back
module data_mem_responder #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned AW      = 9
) (
   input  logic                clk,
   input  logic                rst,
   data_mem_responder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
   localparam int unsigned DEPTH    = 1 << AW;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          done_q;
   logic          err_q;
   logic          op_wr_q;
   logic [AW-1:0] word_q;
   logic [15:0]   wdata_q;
   logic [15:0]   rdata_q;
   logic [15:0]   mem_q [DEPTH];

   logic          any_req;
   logic          req_legal;
   logic          req_illegal;
   logic          in_busy;
   logic          accept;
   logic          commit;
   logic          commit_wr;
   logic [AW-1:0] commit_word;
   logic [15:0]   commit_data;
   logic [AW-1:0] req_word;
   logic          unused_addr_bits;

   // Upper byte-address bits alias onto the same word.
   assign req_word         = bus.addr[AW:1];
   assign unused_addr_bits = ^bus.addr[15:AW+1];

   always_comb begin
      any_req     = bus.memRead | bus.memWrite;
      req_legal   = (bus.memRead ^ bus.memWrite) & ~bus.addr[0];
      req_illegal = any_req & ~req_legal;
      in_busy     = (state_q == S_BUSY);
      accept      = ~in_busy & req_legal;
      // With LATENCY=1 the access completes on its acceptance edge, so it uses the live request.
      commit      = (in_busy && cnt_q == 4'd0) || (accept && LATENCY == 1);
      commit_wr   = in_busy ? op_wr_q : bus.memWrite;
      commit_word = in_busy ? word_q  : req_word;
      commit_data = in_busy ? wdata_q : bus.writeData;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 16'd0;
         op_wr_q <= 1'b0;
         word_q  <= '0;
         wdata_q <= 16'd0;
      end else begin
         done_q <= commit;
         err_q  <= ~in_busy & req_illegal;
         if (commit && !commit_wr) begin
            rdata_q <= mem_q[commit_word];
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  word_q  <= req_word;
                  wdata_q <= bus.writeData;
                  op_wr_q <= bus.memWrite;
                  if (LATENCY == 1) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_BUSY;
                     cnt_q   <= CNT_INIT;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_BUSY: begin
               if (cnt_q == 4'd0) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Storage is not reset; a reset on the completing edge discards the pending write.
   always_ff @(posedge clk) begin
      if (!rst && commit && commit_wr) begin
         mem_q[commit_word] <= commit_data;
      end
   end

   assign bus.readData = rdata_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.stall    = accept | in_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three latencies driven by one stimulus stream, checked against a
// per-instance transaction model plus directed vectors and sequences.
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] s_addr;
   logic [15:0] s_wdata;
   logic        s_rd;
   logic        s_wr;

   data_mem_responder_if if1 ();
   data_mem_responder_if if2 ();
   data_mem_responder_if if3 ();

   assign if1.addr = s_addr;  assign if1.writeData = s_wdata;
   assign if1.memRead = s_rd; assign if1.memWrite = s_wr;
   assign if2.addr = s_addr;  assign if2.writeData = s_wdata;
   assign if2.memRead = s_rd; assign if2.memWrite = s_wr;
   assign if3.addr = s_addr;  assign if3.writeData = s_wdata;
   assign if3.memRead = s_rd; assign if3.memWrite = s_wr;

   data_mem_responder #(.LATENCY(1), .AW(9)) u_l1 (.clk(clk), .rst(rst), .bus(if1));
   data_mem_responder #(.LATENCY(2), .AW(9)) u_l2 (.clk(clk), .rst(rst), .bus(if2));
   data_mem_responder #(.LATENCY(3), .AW(9)) u_l3 (.clk(clk), .rst(rst), .bus(if3));

   logic [15:0] o_rd    [3];
   logic        o_done  [3];
   logic        o_stall [3];
   logic        o_err   [3];
   assign o_rd[0] = if1.readData; assign o_done[0] = if1.done; assign o_stall[0] = if1.stall; assign o_err[0] = if1.err;
   assign o_rd[1] = if2.readData; assign o_done[1] = if2.done; assign o_stall[1] = if2.stall; assign o_err[1] = if2.err;
   assign o_rd[2] = if3.readData; assign o_done[2] = if3.done; assign o_stall[2] = if3.stall; assign o_err[2] = if3.err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction model: each instance owns at most one access that completes at cycle fin.
   int          fin    [3];
   int          err_at [3];
   bit          pend   [3];
   bit          pend_wr[3];
   int          pend_w [3];
   logic [15:0] pend_d [3];
   logic [15:0] m_rd   [3];
   bit          m_rdk  [3];
   logic [15:0] mmem   [3][512];
   bit          mknown [3][512];
   bit          armed = 1'b0;
   bit          m_legal, m_illegal, m_busy;

   always @(negedge clk) begin
      m_legal   = (s_rd ^ s_wr) && !s_addr[0];
      m_illegal = (s_rd || s_wr) && !m_legal;
      for (int k = 0; k < 3; k++) begin
         if (armed) begin
            if (pend[k] && fin[k] == cyc) begin
               pend[k] = 1'b0;
               if (pend_wr[k]) begin
                  mmem[k][pend_w[k]]   = pend_d[k];
                  mknown[k][pend_w[k]] = 1'b1;
               end else begin
                  m_rd[k]  = mmem[k][pend_w[k]];
                  m_rdk[k] = mknown[k][pend_w[k]];
               end
            end
            m_busy = cyc < fin[k];
            check($sformatf("model L%0d done", k + 1),  16'(o_done[k]),  16'(fin[k] == cyc));
            check($sformatf("model L%0d err", k + 1),   16'(o_err[k]),   16'(err_at[k] == cyc));
            check($sformatf("model L%0d stall", k + 1), 16'(o_stall[k]), 16'(m_busy || m_legal));
            if (m_rdk[k]) check($sformatf("model L%0d readData", k + 1), o_rd[k], m_rd[k]);
         end
         m_busy = cyc < fin[k];
         if (rst) begin
            fin[k] = -1; err_at[k] = -1; pend[k] = 1'b0;
            m_rd[k] = 16'd0; m_rdk[k] = 1'b1;
         end else if (armed && !m_busy) begin
            if (m_legal) begin
               pend[k] = 1'b1; pend_wr[k] = s_wr; pend_w[k] = int'(s_addr[9:1]);
               pend_d[k] = s_wdata; fin[k] = cyc + k + 1;
            end else if (m_illegal) begin
               err_at[k] = cyc + 1;
            end
         end
      end
      if (rst) armed = 1'b1;
   end

   task automatic put(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
      s_rd = rd; s_wr = wr; s_addr = a; s_wdata = d;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit rd; bit wr; logic [15:0] a; logic [15:0] d;
      bit e_done; bit e_stall; bit e_err; logic [15:0] e_rd;
   } vec_t;

   function automatic vec_t mk(bit rd, bit wr, logic [15:0] a, logic [15:0] d,
                               bit e_done, bit e_stall, bit e_err, logic [15:0] e_rd);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a = a; v.d = d;
      v.e_done = e_done; v.e_stall = e_stall; v.e_err = e_err; v.e_rd = e_rd;
      return v;
   endfunction

   int          pool  [6] = '{1, 8, 16, 32, 85, 511};
   logic [15:0] pinit [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
   vec_t        tbl   [15];

   initial begin
      int unsigned r;
      int unsigned hi;
      int unsigned w;
      int unsigned a0;

      tbl[0]  = mk(0, 1, 16'h0040, 16'hBEEF, 0, 1, 0, 16'h0000);
      tbl[1]  = mk(0, 1, 16'h0040, 16'hBEEF, 0, 1, 0, 16'h0000);
      tbl[2]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000);
      tbl[3]  = mk(1, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'h0000);
      tbl[4]  = mk(1, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'h0000);
      tbl[5]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF);
      tbl[6]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hBEEF);
      tbl[7]  = mk(1, 1, 16'h0040, 16'h1111, 0, 0, 0, 16'hBEEF);
      tbl[8]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'hBEEF);
      tbl[9]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hBEEF);
      tbl[10] = mk(1, 0, 16'h0041, 16'h0000, 0, 0, 0, 16'hBEEF);
      tbl[11] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'hBEEF);
      tbl[12] = mk(1, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'hBEEF);
      tbl[13] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF);
      tbl[14] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF);

      rst = 1'b1;
      put(0, 0, 16'h0, 16'h0);
      repeat (2) step();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset L%0d done", k + 1),     16'(o_done[k]),  16'd0);
         check($sformatf("reset L%0d err", k + 1),      16'(o_err[k]),   16'd0);
         check($sformatf("reset L%0d stall", k + 1),    16'(o_stall[k]), 16'd0);
         check($sformatf("reset L%0d readData", k + 1), o_rd[k],         16'd0);
      end
      step();
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         put(0, 1, 16'(pool[i] << 1), pinit[i]);
         step();
         put(0, 0, 16'h0, 16'h0);
         repeat (4) step();
      end

      // LATENCY=2 write/read, illegal requests
      for (int i = 0; i < 15; i++) begin
         put(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
         @(negedge clk);
         check($sformatf("vec%0d done", i),     16'(o_done[1]),  16'(tbl[i].e_done));
         check($sformatf("vec%0d stall", i),    16'(o_stall[1]), 16'(tbl[i].e_stall));
         check($sformatf("vec%0d err", i),      16'(o_err[1]),   16'(tbl[i].e_err));
         check($sformatf("vec%0d readData", i), o_rd[1],         tbl[i].e_rd);
         step();
      end
      put(0, 0, 16'h0, 16'h0);
      repeat (4) step();

      // LATENCY=3 back-to-back write then read of the same word
      for (int t = 0; t < 7; t++) begin
         if (t < 3)      put(0, 1, 16'h0010, 16'h1234);
         else if (t < 6) put(1, 0, 16'h0010, 16'h0000);
         else            put(0, 0, 16'h0000, 16'h0000);
         @(negedge clk);
         check($sformatf("b2b t%0d stall", t), 16'(o_stall[2]), 16'(t < 6));
         check($sformatf("b2b t%0d done", t),  16'(o_done[2]),  16'(t == 3 || t == 6));
         if (t == 6) check("b2b readData", o_rd[2], 16'h1234);
         step();
      end
      repeat (4) step();

      // Reset during the BUSY cycle of a write
      put(0, 1, 16'h0020, 16'hAAAA);
      @(negedge clk);
      check("rstmid accept stall L2", 16'(o_stall[1]), 16'd1);
      step();
      put(0, 0, 16'h0, 16'h0);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid busy stall L2", 16'(o_stall[1]), 16'd1);
      check("rstmid busy stall L3", 16'(o_stall[2]), 16'd1);
      step();
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rstmid L%0d done", k + 1),     16'(o_done[k]),  16'd0);
         check($sformatf("rstmid L%0d stall", k + 1),    16'(o_stall[k]), 16'd0);
         check($sformatf("rstmid L%0d readData", k + 1), o_rd[k],         16'd0);
      end
      step();
      put(1, 0, 16'h0020, 16'h0);
      step();
      put(0, 0, 16'h0, 16'h0);
      repeat (3) step();
      @(negedge clk);
      check("rstmid old data L2", o_rd[1], 16'h3333);
      check("rstmid old data L3", o_rd[2], 16'h3333);
      check("rstmid committed L1", o_rd[0], 16'hAAAA);
      step();

      // LATENCY=1 with aliased addresses
      put(0, 1, 16'h0402, 16'h5A5A);
      @(negedge clk);
      check("alias wr stall", 16'(o_stall[0]), 16'd1);
      check("alias wr done early", 16'(o_done[0]), 16'd0);
      step();
      put(0, 0, 16'h0, 16'h0);
      @(negedge clk);
      check("alias wr done", 16'(o_done[0]), 16'd1);
      check("alias wr stall after", 16'(o_stall[0]), 16'd0);
      step();
      put(1, 0, 16'h0002, 16'h0);
      @(negedge clk);
      check("alias rd stall", 16'(o_stall[0]), 16'd1);
      step();
      put(0, 0, 16'h0, 16'h0);
      @(negedge clk);
      check("alias rd done", 16'(o_done[0]), 16'd1);
      check("alias rd data", o_rd[0], 16'h5A5A);
      check("alias rd stall after", 16'(o_stall[0]), 16'd0);
      step();
      repeat (4) step();

      // Random traffic, checked by the model
      for (int i = 0; i < 3000; i++) begin
         r  = $urandom_range(99);
         hi = $urandom_range(63);
         w  = pool[$urandom_range(5)];
         a0 = ($urandom_range(7) == 0) ? 1 : 0;
         s_addr  = 16'((hi << 10) | (w << 1) | a0);
         s_wdata = 16'($urandom);
         s_rd    = (r >= 40 && r < 65) || r >= 90;
         s_wr    = (r >= 65);
         rst     = ($urandom_range(199) == 0);
         step();
      end
      rst = 1'b0;
      put(0, 0, 16'h0, 16'h0);
      repeat (5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
